adc_spi_responder: RTL

- SPI slave that emulates an ADC128S-style 8-channel, 12-bit converter from the responder side of the A2D SPI link.
- Receives 16-bit command frames from the A2D master interface and extracts the channel from each one.
- Returns, in the following frame, the 12-bit sample for the channel addressed in the previous frame.
- Used as a synthesizable stand-in for the external ADC in FPGA bring-up and system-level benches; samples come from an external source via a channel-select/sample port pair.

---
 rtl/adc_spi_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel, 12-bit ADC128S-style converter.
// Commands carry the channel in bits [13:11]; each frame returns the sample requested in the previous one.
module adc_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] RST_CHNL    = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [2:0]  sel_chnl,
    input  logic [11:0] smpl,
    output logic        frame_done,
    output logic [15:0] rx_word,
    output logic        frame_err,
    input  logic        clr_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] ss_chain;
    logic [SYNC_STAGES-1:0] sclk_chain;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   ss_prev;
    logic                   sclk_prev;

    logic ss_sync;
    logic sclk_sync;
    logic mosi_sync;
    logic ss_fall;
    logic ss_rise;
    logic sclk_rise;
    logic sclk_fall;

    state_t      state;
    logic [4:0]  bit_cnt;
    logic        rise_seen;
    logic [15:0] rx_shift;
    logic [15:0] tx_shift;

    // Synchronizer chains preset to the idle bus levels so reset never fakes an edge on SS_n
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_chain   <= {SYNC_STAGES{1'b1}};
            sclk_chain <= {SYNC_STAGES{1'b1}};
            mosi_chain <= {SYNC_STAGES{1'b0}};
            ss_prev    <= 1'b1;
            sclk_prev  <= 1'b1;
        end else begin
            ss_chain   <= {ss_chain[SYNC_STAGES-2:0], SS_n};
            sclk_chain <= {sclk_chain[SYNC_STAGES-2:0], SCLK};
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
            ss_prev    <= ss_chain[SYNC_STAGES-1];
            sclk_prev  <= sclk_chain[SYNC_STAGES-1];
        end
    end

    assign ss_sync   = ss_chain[SYNC_STAGES-1];
    assign sclk_sync = sclk_chain[SYNC_STAGES-1];
    assign mosi_sync = mosi_chain[SYNC_STAGES-1];

    assign ss_fall   = ss_prev & ~ss_sync;
    assign ss_rise   = ~ss_prev & ss_sync;
    assign sclk_rise = ~sclk_prev & sclk_sync;
    assign sclk_fall = sclk_prev & ~sclk_sync;

    // Frame FSM: shift in on SCLK rise, shift out on SCLK fall, commit on SS_n rise.
    // Error sets come after the clear so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_chnl   <= RST_CHNL;
            frame_done <= 1'b0;
            rx_word    <= 16'h0000;
            frame_err  <= 1'b0;
            bit_cnt    <= 5'd0;
            rise_seen  <= 1'b0;
            rx_shift   <= 16'h0000;
            tx_shift   <= 16'h0000;
        end else begin
            frame_done <= 1'b0;
            if (clr_err) begin
                frame_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state     <= ACTIVE;
                        tx_shift  <= {4'b0000, smpl};
                        bit_cnt   <= 5'd0;
                        rise_seen <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state <= IDLE;
                        if (bit_cnt == 5'd16) begin
                            rx_word    <= rx_shift;
                            sel_chnl   <= rx_shift[13:11];
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        rx_shift  <= {rx_shift[14:0], mosi_sync};
                        rise_seen <= 1'b1;
                        if (bit_cnt == 5'd16) begin
                            frame_err <= 1'b1;
                            bit_cnt   <= 5'd17;
                        end else if (bit_cnt != 5'd17) begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (sclk_fall && rise_seen &&
                                 (bit_cnt >= 5'd1) && (bit_cnt <= 5'd15)) begin
                        // Falls before the first rise keep bit 15 in place for idle-high SCLK
                        tx_shift <= {tx_shift[14:0], 1'b0};
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign MISO = (state == ACTIVE) ? tx_shift[15] : 1'b0;

endmodule
